p_mem_arbiter: RTL and testbench
================================

// Module: p_mem_arbiter
// PURPOSE
//  Sits directly downstream of the pipelined I-cache and the D-cache physical-memory ports.
//  Serialises their 256-bit line requests onto the single physical-memory / cacheline-adapter port.
//  Latches each granted request, registers the returned line and returns a one-cycle resp to the winner.
//  I-cache is read-only; the D-cache may read or write back.
// PARAMETERS
//  s_addr  32   address width (bits)
//  s_line  256  cache line width (bits)
// PORTS
//  clk             in   1       single clock, all state on posedge
//  rst             in   1       synchronous, active-high reset
//  i_pmem_read     in   1       I-cache line read request
//  i_pmem_address  in   s_addr  I-cache line address
//  i_pmem_rdata    out  s_line  line returned to I-cache
//  i_pmem_resp     out  1       I-cache transaction complete
//  d_pmem_read     in   1       D-cache line read request
//  d_pmem_write    in   1       D-cache line write-back request
//  d_pmem_address  in   s_addr  D-cache line address
//  d_pmem_wdata    in   s_line  D-cache write-back line
//  d_pmem_rdata    out  s_line  line returned to D-cache
//  d_pmem_resp     out  1       D-cache transaction complete
//  pmem_read       out  1       memory read strobe
//  pmem_write      out  1       memory write strobe
//  pmem_address    out  s_addr  memory address (latched)
//  pmem_wdata      out  s_line  memory write line (latched)
//  pmem_rdata      in   s_line  memory read line
//  pmem_resp       in   1       memory transaction complete
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=GRANT_D; every output, latch and line register = 0.
//  IDLE: requests are sampled only in IDLE; i_req=i_pmem_read, d_req=d_pmem_read|d_pmem_write.
//   Grant rules:
//    - Single requester is granted.
//    - Both requesting: D wins (see CONFIGURATION).
//    - On grant: latch address, op and wdata (wdata=0 for an I grant); go BUSY.
//   No request: stay IDLE.
//  BUSY:
//   - pmem_read/pmem_write driven from the latched op (exactly one high); pmem_address/pmem_wdata come from the latch.
//   - Stays BUSY until pmem_resp; then captures pmem_rdata into line_q and goes RESP.
//  RESP:
//   - Granted client's resp=1 for exactly one cycle; the other resp stays 0.
//   - last_grant updated; next state IDLE.
//   - pmem strobes are 0 in RESP and IDLE.
//  i_pmem_rdata and d_pmem_rdata are both driven from line_q; valid only with their resp.
//  Latency:
//   - Request seen in IDLE at cycle t -> pmem strobe high at t+1.
//   - pmem_resp at cycle r -> client resp at r+1.
//   - Next arbitration at r+2.
//   - Zero-wait memory: 3 cycles from request to resp.
//  Boundary conditions:
//   - d_pmem_read and d_pmem_write both high: write wins.
//   - Client drops its request during BUSY: transaction still completes and resp is still issued.
//   - Address/wdata changes after grant are ignored.
//   - pmem_resp in IDLE or RESP is ignored.
//   - Client request still high in the RESP cycle is not re-granted; it is re-sampled in IDLE.
//   - rst mid-transaction: IDLE next cycle, strobes drop, in-flight pmem_resp discarded, no client resp.
// CONFIGURATION
//  Macro: ARB_ROUND_ROBIN_EN
//  Defined: on simultaneous requests, the client that was NOT last_grant wins. After reset (last_grant=D), I wins the first tie.
//  Undefined: fixed priority, D always wins ties; last_grant is still maintained but unused.
// STRUCTURE
//  Shared package mem_arb_types:
//   - arb_state_t enum {IDLE, BUSY, RESP}
//   - arb_grant_t enum {GRANT_I, GRANT_D}
//   - arb_op_t enum {OP_READ, OP_WRITE}
//  No sub-module: one FSM and the request/line registers in a single module.
// TESTING
//  1. Reset, then i_pmem_read=1 @0x0000_0060; mem returns line 0xA5..A5 after 2 cycles -> pmem_read 1 cycle after request, i_pmem_resp one cycle with rdata=0xA5..A5, d_pmem_resp=0.
//  2. D write-back @0x0000_1000, wdata=0x1234..: pmem_write=1, pmem_address=0x1000, pmem_wdata=0x1234..; d_pmem_resp one cycle after pmem_resp.
//  3. I and D read same cycle, macro undefined -> D served first, then I; both complete, no overlap of strobes.
//  4. Same as 3 with ARB_ROUND_ROBIN_EN -> I first (post-reset tie), then D; repeated ties alternate I,D,I,D.
//  5. Change i_pmem_address 0x60->0x80 during BUSY -> pmem_address stays 0x60 until resp.
//  6. Assert rst while BUSY, then pmem_resp next cycle -> no i/d resp, pmem_read=0, state IDLE, outputs 0.

Source files
------------

// File: rtl/p_mem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: FSM states, grant owner and latched op.
// The tie-break policy itself lives in p_mem_arbiter (see ARB_ROUND_ROBIN_EN there).
package mem_arb_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

endpackage

// File: rtl/p_mem_arbiter.sv
// Serialises I-cache and D-cache line requests onto one physical-memory port.
// Tie policy: fixed D priority by default, alternating when ARB_ROUND_ROBIN_EN is defined.
module p_mem_arbiter
    import mem_arb_types::*;
#(
    parameter int s_addr = 32,
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [s_addr-1:0] i_pmem_address,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [1:0]        dbg_state_o,
    output logic              dbg_last_grant_o
);

    arb_state_t        state_q;
    arb_grant_t        grant_q, grant_d, last_grant_q;
    arb_op_t           op_q, op_d;
    logic [s_addr-1:0] addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic [s_line-1:0] line_q;
    logic              i_resp_q, d_resp_q;
    logic              i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Winner and its request fields, only consumed in IDLE.
    always_comb begin
        grant_d = GRANT_D;
        if (i_req && !d_req) begin
            grant_d = GRANT_I;
        end else if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_d = (last_grant_q == GRANT_D) ? GRANT_I : GRANT_D;
`else
            grant_d = GRANT_D;
`endif
        end
        // A D-cache asserting both strobes is a write-back.
        op_d    = (grant_d == GRANT_D && d_pmem_write) ? OP_WRITE : OP_READ;
        addr_d  = (grant_d == GRANT_D) ? d_pmem_address : i_pmem_address;
        wdata_d = (grant_d == GRANT_D) ? d_pmem_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_D;
            op_q         <= OP_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant_q <= grant_d;
                        op_q    <= op_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        line_q   <= pmem_rdata;
                        i_resp_q <= (grant_q == GRANT_I);
                        d_resp_q <= (grant_q == GRANT_D);
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    i_resp_q     <= 1'b0;
                    d_resp_q     <= 1'b0;
                    last_grant_q <= grant_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem_read        = (state_q == BUSY) && (op_q == OP_READ);
    assign pmem_write       = (state_q == BUSY) && (op_q == OP_WRITE);
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign i_pmem_rdata     = line_q;
    assign d_pmem_rdata     = line_q;
    assign i_pmem_resp      = i_resp_q;
    assign d_pmem_resp      = d_resp_q;
    assign dbg_state_o      = state_q;
    assign dbg_last_grant_o = last_grant_q;

endmodule

// File: tb/tb_p_mem_arbiter.sv
// Bench for p_mem_arbiter: directed scenarios then randomized rounds against a transaction-level model.
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating tie policy.
module tb_p_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [1:0]   dbg_state_o;
    logic         dbg_last_grant_o;

    int checks = 0;
    int errors = 0;
    bit last_d;  // model: most recently completed grant was the D-cache

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    p_mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .i_pmem_read      (i_pmem_read),
        .i_pmem_address   (i_pmem_address),
        .i_pmem_rdata     (i_pmem_rdata),
        .i_pmem_resp      (i_pmem_resp),
        .d_pmem_read      (d_pmem_read),
        .d_pmem_write     (d_pmem_write),
        .d_pmem_address   (d_pmem_address),
        .d_pmem_wdata     (d_pmem_wdata),
        .d_pmem_rdata     (d_pmem_rdata),
        .d_pmem_resp      (d_pmem_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp),
        .dbg_state_o      (dbg_state_o),
        .dbg_last_grant_o (dbg_last_grant_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // Model tie rule: who wins when both clients request together.
    function automatic bit tie_goes_to_d();
`ifdef ARB_ROUND_ROBIN_EN
        return !last_d;
`else
        return 1'b1;
`endif
    endfunction

    // One arbitration round starting at an IDLE-cycle negedge. New requests are
    // only added for clients not already waiting; the loser keeps waiting.
    task automatic round(input bit ni, input bit nd, input bit dr, input bit dw,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [255:0] dwd, input logic [255:0] line,
                         input int lat, input bit drop, input bit mutate);
        bit           i_on, d_on, win_d, exp_wr;
        logic [31:0]  exp_a;
        logic [255:0] exp_w;
        if (ni && !i_pmem_read) begin
            i_pmem_read    = 1'b1;
            i_pmem_address = ia;
        end
        if (nd && (dr || dw) && !(d_pmem_read || d_pmem_write)) begin
            d_pmem_read    = dr;
            d_pmem_write   = dw;
            d_pmem_address = da;
            d_pmem_wdata   = dwd;
        end
        i_on = i_pmem_read;
        d_on = d_pmem_read || d_pmem_write;
        if (!i_on && !d_on) begin
            pmem_resp  = 1'($urandom_range(0, 1));
            pmem_rdata = rand_line();
            tick();
            pmem_resp = 1'b0;
            check("idle_state", 256'(dbg_state_o), 256'(ST_IDLE));
            check("idle_strobes", 256'({pmem_read, pmem_write}), 256'(0));
            check("idle_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
            return;
        end
        win_d  = (i_on && d_on) ? tie_goes_to_d() : d_on;
        exp_wr = win_d && d_pmem_write;
        exp_a  = win_d ? d_pmem_address : i_pmem_address;
        exp_w  = exp_wr ? d_pmem_wdata : (win_d ? d_pmem_wdata : 256'(0));
        tick();
        check("busy_state", 256'(dbg_state_o), 256'(ST_BUSY));
        check("busy_read", 256'(pmem_read), 256'(!exp_wr));
        check("busy_write", 256'(pmem_write), 256'(exp_wr));
        check("busy_addr", 256'(pmem_address), 256'(exp_a));
        check("busy_wdata", pmem_wdata, exp_w);
        check("busy_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
        if (mutate) begin
            if (win_d) begin
                d_pmem_address = d_pmem_address + 32'h20;
                d_pmem_wdata   = rand_line();
            end else begin
                i_pmem_address = i_pmem_address + 32'h20;
            end
        end
        if (drop) begin
            if (win_d) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end else begin
                i_pmem_read = 1'b0;
            end
        end
        for (int k = 0; k < lat; k++) begin
            tick();
            check("wait_strobe", 256'({pmem_read, pmem_write}), 256'({!exp_wr, exp_wr}));
            check("wait_addr", 256'(pmem_address), 256'(exp_a));
            check("wait_wdata", pmem_wdata, exp_w);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = line;
        tick();
        pmem_resp  = 1'($urandom_range(0, 1));
        pmem_rdata = rand_line();
        check("resp_state", 256'(dbg_state_o), 256'(ST_RESP));
        check("resp_flags", 256'({i_pmem_resp, d_pmem_resp}), 256'({!win_d, win_d}));
        check("resp_rdata", win_d ? d_pmem_rdata : i_pmem_rdata, line);
        check("resp_strobes", 256'({pmem_read, pmem_write}), 256'(0));
        tick();
        pmem_resp = 1'b0;
        last_d    = win_d;
        check("post_state", 256'(dbg_state_o), 256'(ST_IDLE));
        check("post_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
        check("post_strobes", 256'({pmem_read, pmem_write}), 256'(0));
        check("post_last", 256'(dbg_last_grant_o), 256'(win_d));
        if (win_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
        end
    endtask

    initial begin
        logic [255:0] a5_line;
        logic [255:0] wb_line;
        a5_line        = {32{8'hA5}};
        wb_line        = {8{32'h1234_5678}};
        rst            = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;
        last_d         = 1'b1;
        repeat (2) tick();
        check("rst_state", 256'(dbg_state_o), 256'(ST_IDLE));
        check("rst_strobes", 256'({pmem_read, pmem_write}), 256'(0));
        check("rst_addr", 256'(pmem_address), 256'(0));
        check("rst_wdata", pmem_wdata, 256'(0));
        check("rst_rdata", i_pmem_rdata | d_pmem_rdata, 256'(0));
        check("rst_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
        check("rst_last", 256'(dbg_last_grant_o), 256'(1));
        rst = 1'b0;

        // I read, memory answers on the second BUSY cycle, address moved 0x60->0x80 mid-flight.
        round(1, 0, 0, 0, 32'h60, 32'h0, '0, a5_line, 1, 0, 1);
        // D write-back.
        round(0, 1, 0, 1, 32'h0, 32'h1000, wb_line, rand_line(), 0, 0, 0);
        // D read and write together: treated as write.
        round(0, 1, 1, 1, 32'h0, 32'h2040, rand_line(), rand_line(), 2, 1, 0);
        // Fresh reset so the first tie sees last_grant=D, then repeated ties.
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        last_d = 1'b1;
        round(1, 1, 1, 0, 32'h100, 32'h200, '0, rand_line(), 0, 0, 0);
        round(1, 1, 1, 0, 32'h140, 32'h240, '0, rand_line(), 1, 0, 0);
        round(1, 1, 1, 0, 32'h180, 32'h280, '0, rand_line(), 0, 0, 0);
        round(0, 0, 0, 0, 32'h0, 32'h0, '0, rand_line(), 0, 0, 0);
        round(0, 0, 0, 0, 32'h0, 32'h0, '0, rand_line(), 0, 0, 0);

        // Reset while BUSY, memory answers afterwards: nothing must come back.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h300;
        tick();
        check("abort_busy", 256'(pmem_read), 256'(1));
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        i_pmem_read = 1'b0;
        pmem_resp   = 1'b1;
        pmem_rdata  = rand_line();
        check("abort_state", 256'(dbg_state_o), 256'(ST_IDLE));
        check("abort_read", 256'(pmem_read), 256'(0));
        tick();
        pmem_resp = 1'b0;
        last_d    = 1'b1;
        check("abort_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
        check("abort_state2", 256'(dbg_state_o), 256'(ST_IDLE));
        check("abort_addr", 256'(pmem_address), 256'(0));
        check("abort_rdata", i_pmem_rdata, 256'(0));

        for (int n = 0; n < 120; n++) begin
            round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom() & 32'hFFFF_FFE0, $urandom() & 32'hFFFF_FFE0,
                  rand_line(), rand_line(), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        // Drain anything still waiting.
        repeat (2) round(0, 0, 0, 0, 32'h0, 32'h0, '0, rand_line(), 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
